// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the sequential multi-word adder: slice width,
// controller states and the slice-index width helper.
package multiword_adder_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index register width; never narrower than one bit.
    function automatic int idx_width(input int num_words);
        return (num_words <= 2) ? 1 : $clog2(num_words);
    endfunction

    // Two's-complement overflow from operand and result sign bits.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb);
    endfunction

endpackage

// File: rtl/multiword_adder_seq_hc16.sv
// 16-bit Han-Carlson prefix adder: Kogge-Stone tree on odd bits, one extra
// level resolves the even bits. Carry-in is folded into bit 0's generate.
module multiword_adder_seq_hc16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    logic [4:0][15:0] g_s;
    logic [4:0][15:0] p_s;
    logic [15:0]      gf_s;

    assign p_s[0] = A ^ B;
    assign g_s[0] = (A & B) | {15'd0, (A[0] ^ B[0]) & Cin};

    // Combining a node with itself is a no-op, so unused positions point at i.
    for (genvar l = 0; l < 4; l++) begin : g_lvl
        for (genvar i = 0; i < 16; i++) begin : g_bit
            localparam int D = 1 << l;
            localparam int J = ((i % 2 == 1) && (i >= D)) ? (i - D) : i;
            assign g_s[l+1][i] = g_s[l][i] | (p_s[l][i] & g_s[l][J]);
            assign p_s[l+1][i] = p_s[l][i] & p_s[l][J];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_even
        localparam int J = ((i % 2 == 0) && (i >= 2)) ? (i - 1) : i;
        assign gf_s[i] = g_s[4][i] | (p_s[4][i] & g_s[4][J]);
    end

    assign Sum  = p_s[0] ^ {gf_s[14:0], Cin};
    assign Cout = gf_s[15];

endmodule

// File: rtl/multiword_adder_seq.sv
// Sequential wide adder/subtractor: streams 16-bit slices LSB first through
// one prefix adder, rippling the carry through a register between cycles.
module multiword_adder_seq
    import multiword_adder_seq_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_WORDS*WORD_W-1:0]   in_a,
    input  logic [NUM_WORDS*WORD_W-1:0]   in_b,
    input  logic                          in_cin,
    input  logic                          in_sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_WORDS*WORD_W-1:0]   out_sum,
    output logic                          out_cout,
    output logic                          out_ovf
);

    localparam int W     = NUM_WORDS * WORD_W;
    localparam int IDX_W = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WORD_W-1:0]  slice_a_s;
    logic [WORD_W-1:0]  slice_b_s;
    logic [WORD_W-1:0]  slice_sum_s;
    logic               slice_cout_s;
    logic               last_s;

    assign slice_a_s = a_r[idx_r*WORD_W +: WORD_W];
    assign slice_b_s = b_r[idx_r*WORD_W +: WORD_W];
    assign last_s    = (idx_r == LAST_IDX);

    multiword_adder_seq_hc16 u_hc16 (
        .A    (slice_a_s),
        .B    (slice_b_s),
        .Cin  (carry_r),
        .Sum  (slice_sum_s),
        .Cout (slice_cout_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (in_valid)  state_nxt_s = RUN;  else state_nxt_s = IDLE;
            RUN:     if (last_s)    state_nxt_s = DONE; else state_nxt_s = RUN;
            DONE:    if (out_ready) state_nxt_s = IDLE; else state_nxt_s = DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            RUN:     in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand capture and per-slice result accumulation; operands load only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx_r    <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_sub ? ~in_b : in_b;
                        carry_r <= in_sub ? 1'b1 : in_cin;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    out_sum[idx_r*WORD_W +: WORD_W] <= slice_sum_s;
                    carry_r <= slice_cout_s;
                    idx_r   <= idx_r + IDX_ONE;
                    if (last_s) begin
                        out_cout <= slice_cout_s;
                        out_ovf  <= signed_ovf(a_r[W-1], b_r[W-1], slice_sum_s[WORD_W-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed bench for multiword_adder_seq with a cycle-level behavioural model
// checked every cycle, plus literal expectations per operation.
module tb_multiword_adder_seq;

    localparam int NW = 4;
    localparam int W  = NW * 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    multiword_adder_seq #(.NUM_WORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Plain wide arithmetic: returns {ovf, cout, sum}
    function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        logic [W-1:0]      bb;
        logic              c;
        logic [W:0]        full;
        logic signed [W:0] sv;
        bb   = sub ? ~b : b;
        c    = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        sv   = $signed({a[W-1], a}) + $signed({bb[W-1], bb}) + $signed({{W{1'b0}}, c});
        return {(sv[W] != sv[W-1]), full[W], full[W-1:0]};
    endfunction

    logic         m_ready;
    logic         m_valid;
    int           m_cnt;
    logic [W+1:0] m_res;

    // Model: busy for NW cycles after accept, then holds result until taken
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_res   <= '0;
        end else if (m_ready && in_valid) begin
            m_ready <= 1'b0;
            m_cnt   <= NW;
            m_res   <= calc(in_a, in_b, in_cin, in_sub);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_valid <= 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", W'(in_ready), W'(m_ready));
            check("out_valid", W'(out_valid), W'(m_valid));
            if (m_valid) begin
                check("model_sum", out_sum, m_res[W-1:0]);
                check("model_cout", W'(out_cout), W'(m_res[W]));
                check("model_ovf", W'(out_ovf), W'(m_res[W+1]));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_ovf, input int hold);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_a = 'x; in_b = 'x; in_cin = 1'bx; in_sub = 1'bx;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", W'(n), W'(NW));
        check("lit_sum", out_sum, e_sum);
        check("lit_cout", W'(out_cout), W'(e_cout));
        check("lit_ovf", W'(out_ovf), W'(e_ovf));
        for (int k = 0; k < hold; k++) begin
            in_valid = (k == 3);
            in_a = 64'h1111_2222_3333_4444;
            in_b = 64'h5555_6666_7777_8888;
            in_cin = 1'b0; in_sub = 1'b0;
            @(negedge clk);
            check("hold_sum", out_sum, e_sum);
            check("hold_ready", W'(in_ready), W'(1'b0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_ready", W'(in_ready), W'(1'b1));
        check("drain_valid", W'(out_valid), W'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_out_sum", out_sum, '0);
        check("rst_out_cout", W'(out_cout), W'(1'b0));
        check("rst_out_ovf", W'(out_ovf), W'(1'b0));
        rst = 1'b0;

        run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 10);
        run_op(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        run_op(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 0);

        // Abort an operation once slice index 2 is active
        @(negedge clk);
        in_a = 64'hDEAD_BEEF_CAFE_F00D; in_b = 64'h0123_4567_89AB_CDEF;
        in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", W'(out_valid), W'(1'b0));
        check("abort_ready", W'(in_ready), W'(1'b1));
        check("abort_sum", out_sum, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op(64'h1234, 64'h0001, 1'b1, 1'b0, 64'h1236, 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
